// File: rtl/mux_port_arbiter.sv
// mux_port_arbiter: round-robin arbiter for a shared 64-bit 4:1 port.
// Ports: clk/rstn, req/last/data_in_0..3 in; gnt/ack/out_valid/out_data/out_last/sel/busy out; out_ready in.

module MUX4T1_64 (
  input  logic [1:0]  sel,
  input  logic [63:0] d0,
  input  logic [63:0] d1,
  input  logic [63:0] d2,
  input  logic [63:0] d3,
  output logic [63:0] y
);

  always_comb begin
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

module mux_port_arbiter #(
  parameter int MAX_BEATS = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  req,
  input  logic [3:0]  last,
  input  logic [63:0] data_in_0,
  input  logic [63:0] data_in_1,
  input  logic [63:0] data_in_2,
  input  logic [63:0] data_in_3,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic [1:0]  sel,
  output logic        busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] MAX_M1 = 8'(MAX_BEATS - 1);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;

  logic [1:0]  pick;
  logic [1:0]  idx;
  logic        found;
  logic        gr_req;
  logic        rel;
  logic        xfer;

  // Rotating priority: scan from the requester after the last owner.
  always_comb begin
    pick  = last_grant_q + 2'd1;
    idx   = pick;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_grant_q + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign gr_req = req[grant_q];
  assign rel    = last[grant_q] |
                  (beat_cnt_q == MAX_M1);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    gnt          = 4'b0000;
    ack          = 4'b0000;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    busy         = 1'b0;
    xfer         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = pick;
          beat_cnt_d = 8'd0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        busy      = 1'b1;
        gnt       = 4'b0001 << grant_q;
        out_valid = gr_req;
        xfer      = gr_req & out_ready;
        out_last  = gr_req & rel;
        if (xfer) ack = 4'b0001 << grant_q;
        if (!gr_req) begin
          // abandon: give up the port without a beat
          last_grant_d = grant_q;
          beat_cnt_d   = 8'd0;
          state_d      = IDLE;
        end else if (xfer) begin
          if (rel) begin
            last_grant_d = grant_q;
            beat_cnt_d   = 8'd0;
            state_d      = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      beat_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign sel = grant_q;

  MUX4T1_64 u_mux (
    .sel (grant_q),
    .d0  (data_in_0),
    .d1  (data_in_1),
    .d2  (data_in_2),
    .d3  (data_in_3),
    .y   (out_data)
  );

endmodule

// File: doc/mux_port_arbiter.md
# mux_port_arbiter

Round-robin arbiter and sequencer for a shared 64-bit 4:1 datapath port. It accepts beat streams from four requesters and grants one at a time. It drives the 2-bit select of an internal `MUX4T1_64` instance and forwards the chosen requester's data downstream under a valid/ready handshake. It sits in front of a shared datapath resource, such as a memory write port or a writeback bus, that several producers must share without collision.

## Interface
Parameters:
- `MAX_BEATS`, default 8: maximum beats per grant before forced release. Legal range 1..255.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req`  in  4  per-requester request/valid; bit i belongs to requester i.
- `last`  in  4  per-requester end-of-burst marker; sampled only with the granted `req`.
- `data_in_0`..`data_in_3`  in  64 each  requester beat data.
- `gnt`  out  4  one-hot grant; all zero when idle.
- `ack`  out  4  one-hot beat-accepted pulse to the granted requester.
- `out_valid`  out  1  downstream beat valid.
- `out_ready`  in  1  downstream ready.
- `out_data`  out  64  selected beat; this is the output of the internal `MUX4T1_64`.
- `out_last`  out  1  end-of-grant marker for the current beat.
- `sel`  out  2  current mux select, which is also the source ID.
- `busy`  out  1  high in BUSY state.

## Operation
- State machine has two states, IDLE and BUSY.
- Registered state: `state`, `grant` (2 b), `last_grant` (2 b), `beat_cnt` (8 b).
- **IDLE:**
  - `gnt` = 0, `out_valid` = 0, `busy` = 0.
  - If `req` ≠ 0, pick the first set bit scanning `last_grant+1`, `last_grant+2`, … modulo 4.
  - Load that index into `grant`, clear `beat_cnt`, and move to BUSY.
- **BUSY:**
  - `gnt` = one-hot(`grant`), `sel` = `grant`.
  - `out_valid` = `req[grant]`.
  - `ack[grant]` = `out_valid & out_ready`. All other `ack` bits are 0.
- **Transfer:** a transfer occurs when `out_valid & out_ready`. On each transfer, `beat_cnt` increments.
- **Release:** release happens on the transfer beat when either of these holds:
  - `last[grant]` = 1, or
  - `beat_cnt == MAX_BEATS-1` (forced release).
- **`out_last`:** `out_last` = `out_valid` & (release condition). `out_last` is therefore asserted on forced release even when `last[grant]` = 0.
- **Abandon:** if `req[grant]` is 0 while in BUSY, the arbiter releases with no transfer. In this case `out_valid` = 0 that cycle.
- **On release or abandon:**
  - `last_grant` ← `grant`.
  - State goes to IDLE.
  - `beat_cnt` ← 0.
- **Width rules:**
  - `beat_cnt` compares against `MAX_BEATS-1`.
  - With `MAX_BEATS` = 1, every beat releases.
  - `sel` is always driven to a valid index (0..3), so `out_data` is never X.
- **Requester data while granted:** requesters must hold `data_in_i` and `last[i]` stable while `req[i]` = 1 and no `ack[i]` has occurred. The arbiter does not check this.

## Timing
- **Reset values (async on `rstn` = 0):**
  - `state` = IDLE, `grant` = 0, `sel` = 0.
  - `last_grant` = 3, so requester 0 wins first.
  - `beat_cnt` = 0.
  - `gnt` = 0, `ack` = 0, `out_valid` = 0, `out_last` = 0, `busy` = 0.
  - `out_data` = `data_in_0`.
- **Grant latency:** `req` sampled high at edge N gives `gnt`/`busy` high after edge N. The first beat can transfer in cycle N+1.
- **Turnaround:** there is one IDLE cycle between consecutive grants, including when the same requester re-requests.
- **Throughput:** during a grant, one beat per cycle while `req` and `out_ready` are both high.
- **Back-pressure:** `out_ready` = 0 holds `grant`, `beat_cnt`, `out_data` and `out_valid` unchanged. No timeout applies.
- **Combinational paths:**
  - `ack`, `out_valid` and `out_last` are combinational from `req`/`last`/`out_ready` in the same cycle.
  - `gnt`, `sel` and `busy` are purely registered.
- **Simultaneous requests:** resolved by rotation only. A requester whose `req` is withdrawn while in IDLE loses nothing.
- **Reset mid-burst:** the burst is dropped immediately, with no `out_last`. After reset, arbitration restarts from requester 0.

## Test plan
- **Single requester:** `req` = 0001, `last` pulsed on the 3rd beat, `out_ready` = 1. Required response:
  - `gnt` = 0001 one cycle after `req`.
  - Three `ack[0]` pulses.
  - `out_last` on beat 3.
  - One IDLE cycle, then `busy` = 0.
- **Full contention:** `req` = 1111 held, every beat has `last` = 1. Grants must follow 0,1,2,3,0,…, each one beat long, separated by single IDLE cycles.
- **Forced release:** `MAX_BEATS` = 8, requester 2 streams with `last` = 0 and requester 3 waiting. Required response:
  - `out_last` = 1 on beat 8.
  - `gnt` moves to 1000 after one IDLE cycle.
  - Requester 2 is re-granted after requester 3 releases.
- **Back-pressure:** `out_ready` low for 5 cycles mid-burst. Required response:
  - `out_valid` stays 1 and `out_data` stays stable.
  - No `ack` during the stall.
  - `beat_cnt` is unchanged.
  - The burst resumes with the correct beat count.
- **Abandon:** the granted requester drops `req` without `last`. Required response:
  - Return to IDLE next cycle.
  - `last_grant` updated.
  - A pending requester is granted afterwards.
- **Async reset:** assert `rstn` = 0 mid-burst between clock edges. All outputs must go to their reset values immediately. The first post-reset grant goes to requester 0 when `req` = 1111.
